// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, control constants and divider state encodings
package div_unit_pkg;
  localparam int RegBus = 32;
  localparam int DoubleRegBus = 64;
  localparam logic RstEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring shift-subtract iteration on the 65-bit working register
module div_step (
  input  logic [64:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] dividend_o
);
  logic [32:0] w_diff;
  always_comb begin
    w_diff = dividend_i[64:32] - {1'b0, divisor_i};
    dividend_o = w_diff[32] ? {dividend_i[63:0], 1'b0} : {w_diff[31:0], dividend_i[31:0], 1'b1};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit DIV/DIVU producing {remainder, quotient} for HI/LO
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic                    busy_o
);
  div_state_e r_state, w_next;
  logic [5:0] r_cnt;
  logic [64:0] r_dividend;
  logic [64:0] w_step;
  logic [31:0] r_divisor;
  logic r_neg_q, r_neg_r;
  logic [DoubleRegBus-1:0] r_result;
  logic r_ready;
  logic [31:0] w_abs1, w_abs2, w_quot, w_rem;
  logic w_go;

  div_step u_step (
    .dividend_i(r_dividend),
    .divisor_i (r_divisor),
    .dividend_o(w_step)
  );

  always_comb begin
    w_go = (start_i == DivStart) && !annul_i;
    w_abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    w_abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    w_quot = r_neg_q ? -r_dividend[31:0] : r_dividend[31:0];
    w_rem = r_neg_r ? -r_dividend[64:33] : r_dividend[64:33];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DivFree:   w_next = !w_go ? DivFree : (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      DivByZero: w_next = DivEnd;
      DivOn:     w_next = annul_i ? DivFree : (r_cnt == 6'd32) ? DivEnd : DivOn;
      DivEnd:    w_next = (start_i == DivStop) ? DivFree : DivEnd;
      default:   w_next = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) r_state <= DivFree;
    else r_state <= w_next;

  // Operand signs are captured at issue so later operand changes cannot affect correction
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_cnt <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor <= ZeroWord;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_result <= {ZeroWord, ZeroWord};
      r_ready <= DivResultNotReady;
    end else begin
      unique case (r_state)
        DivFree: if (w_next == DivOn) begin
          r_cnt <= 6'd0;
          r_dividend <= {32'd0, w_abs1, 1'b0};
          r_divisor <= w_abs2;
          r_neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          r_neg_r <= signed_div_i && opdata1_i[31];
        end
        DivByZero: begin
          r_result <= {ZeroWord, ZeroWord};
          r_ready <= DivResultReady;
        end
        DivOn: if (!annul_i) begin
          if (r_cnt != 6'd32) begin
            r_dividend <= w_step;
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem, w_quot};
            r_ready <= DivResultReady;
            r_cnt <= 6'd0;
          end
        end
        DivEnd: if (start_i == DivStop) begin
          r_result <= {ZeroWord, ZeroWord};
          r_ready <= DivResultNotReady;
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o = r_ready;
  assign busy_o = (r_state != DivFree);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  logic busy_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  logic prev_ready = 1'b0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (sb.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
      else check("scoreboard_result", result_o, sb.pop_front());
    end
    prev_ready = ready_o;
  end

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_edges, input int hold,
                        input string nm);
    int edges;
    logic busy_ok;
    edges = 0;
    busy_ok = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!busy_o) busy_ok = 1'b0;
      if (edges == 1) begin opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd0; end
    end while (!ready_o && edges < 100);
    check({nm, "_latency"}, 64'(edges), 64'(exp_edges));
    check({nm, "_busy"}, {63'd0, busy_ok}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
      check({nm, "_hold_result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check({nm, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    check({nm, "_drop_busy"}, {63'd0, busy_o}, 64'd0);
    check({nm, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 0, "divu_100_7");
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 0, "div_m7_2");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1, "div_min_m1");
    run_op(1'b0, 32'd5, 32'd0, 64'd0, 2, 3, "divu_by_zero");
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ready_o) seen = 1'b1; end
    check("annul_no_ready", {63'd0, seen}, 64'd0);
    run_op(1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 34, 0, "divu_9_4");
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFC18; opdata2_i = 32'd10; start_i = 1'b1;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", result_o, 64'd0);
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    run_op(1'b1, 32'hFFFFFC18, 32'd10, 64'h00000000_FFFFFF9C, 34, 0, "div_m1000_10");
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
